// File: rtl/gps_spi_bridge.sv
// GPS baseband sample packer with a word FIFO and a framed SPI master toward the MCU.
// MCU_SCK is the inverted system clock gated by a registered enable, so it rises mid bit cell.
module gps_spi_bridge #(
   parameter int unsigned NCH         = 2,
   parameter int unsigned SAMPLE_BITS = 2,
   parameter int unsigned WORD_BITS   = 16,
   parameter int unsigned FIFO_DEPTH  = 4,
   parameter int unsigned SS_HOLD     = 2
) (
   input  logic                                MCU_CLK,
   input  logic                                RESET_N,
   input  logic [NCH*SAMPLE_BITS-1:0]          GPS_DATA,
   input  logic                                GPS_STROBE,
   input  logic                                SELF_TEST,
   input  logic                                DATAREADY,
   output logic                                MCU_SCK,
   output logic                                MCU_SS,
   output logic                                MCU_MOSI,
   output logic                                OVERFLOW,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]     FIFO_LEVEL
);

   localparam int unsigned S  = NCH * SAMPLE_BITS;
   localparam int unsigned K  = WORD_BITS / S;
   localparam int unsigned KW = (K > 1) ? $clog2(K) : 1;
   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam int unsigned LW = $clog2(FIFO_DEPTH + 1);
   localparam int unsigned BW = $clog2(WORD_BITS);
   localparam int unsigned HW = $clog2(SS_HOLD + 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_HOLD  = 2'd2
   } state_t;

   // packer state
   logic [S-1:0]          r_stcnt;
   logic [KW-1:0]         r_cnt;
   logic [WORD_BITS-1:0]  r_pack;

   // fifo state
   logic [WORD_BITS-1:0]  r_mem [FIFO_DEPTH];
   logic [AW-1:0]         r_wr;
   logic [AW-1:0]         r_rd;
   logic [LW-1:0]         r_level;
   logic                  r_ovf;

   // shifter state
   state_t                r_state;
   logic [WORD_BITS-1:0]  r_shreg;
   logic [BW-1:0]         r_bit;
   logic [HW-1:0]         r_hold;
   logic                  r_sck_en;
   logic                  r_ss;
   logic                  r_mosi;

   logic [S-1:0]          w_src;
   logic [WORD_BITS-1:0]  w_pack_next;
   logic [WORD_BITS-1:0]  w_head;
   logic                  w_push;
   logic                  w_full;
   logic                  w_empty;
   logic                  w_pop;
   logic                  w_wr_en;

   assign w_src       = SELF_TEST ? r_stcnt : GPS_DATA;
   assign w_pack_next = (r_pack << S) | WORD_BITS'(w_src);
   assign w_push      = GPS_STROBE && (r_cnt == KW'(K - 1));
   assign w_full      = (r_level == LW'(FIFO_DEPTH));
   assign w_empty     = (r_level == LW'(0));
   assign w_pop       = (r_state == S_IDLE) && !w_empty && DATAREADY;
   // a full FIFO still takes a word when the shifter pops on the same edge
   assign w_wr_en     = w_push && (!w_full || w_pop);
   assign w_head      = r_mem[r_rd];

   // sample packer and self-test counter
   always_ff @(posedge MCU_CLK) begin
      if (!RESET_N) begin
         r_stcnt <= '0;
         r_cnt   <= '0;
         r_pack  <= '0;
      end else begin
         if (!SELF_TEST)
            r_stcnt <= '0;
         else if (GPS_STROBE)
            r_stcnt <= r_stcnt + S'(1);
         if (GPS_STROBE) begin
            r_pack <= w_pack_next;
            r_cnt  <= w_push ? KW'(0) : r_cnt + KW'(1);
         end
      end
   end

   // fifo storage: contents are meaningless while level is 0, so no reset
   always_ff @(posedge MCU_CLK) begin
      if (w_wr_en)
         r_mem[r_wr] <= w_pack_next;
   end

   // fifo pointers, level and sticky overflow
   always_ff @(posedge MCU_CLK) begin
      if (!RESET_N) begin
         r_wr    <= '0;
         r_rd    <= '0;
         r_level <= '0;
         r_ovf   <= 1'b0;
      end else begin
         if (w_wr_en)
            r_wr <= r_wr + AW'(1);
         if (w_pop)
            r_rd <= r_rd + AW'(1);
         if (w_wr_en && !w_pop)
            r_level <= r_level + LW'(1);
         else if (!w_wr_en && w_pop)
            r_level <= r_level - LW'(1);
         if (w_push && !w_wr_en)
            r_ovf <= 1'b1;
      end
   end

   // SPI frame shifter
   always_ff @(posedge MCU_CLK) begin
      if (!RESET_N) begin
         r_state  <= S_IDLE;
         r_shreg  <= '0;
         r_bit    <= '0;
         r_hold   <= '0;
         r_sck_en <= 1'b0;
         r_ss     <= 1'b1;
         r_mosi   <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_pop) begin
                  r_shreg  <= w_head << 1;
                  r_mosi   <= w_head[WORD_BITS-1];
                  r_bit    <= BW'(WORD_BITS - 1);
                  r_ss     <= 1'b0;
                  r_sck_en <= 1'b1;
                  r_state  <= S_SHIFT;
               end
            end
            S_SHIFT: begin
               if (r_bit == BW'(0)) begin
                  r_sck_en <= 1'b0;
                  r_mosi   <= 1'b0;
                  r_ss     <= 1'b1;
                  r_hold   <= HW'(SS_HOLD);
                  r_state  <= S_HOLD;
               end else begin
                  r_mosi  <= r_shreg[WORD_BITS-1];
                  r_shreg <= r_shreg << 1;
                  r_bit   <= r_bit - BW'(1);
               end
            end
            S_HOLD: begin
               r_hold <= r_hold - HW'(1);
               if (r_hold == HW'(1))
                  r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign MCU_SCK    = ~MCU_CLK & r_sck_en;
   assign MCU_SS     = r_ss;
   assign MCU_MOSI   = r_mosi;
   assign OVERFLOW   = r_ovf;
   assign FIFO_LEVEL = r_level;

endmodule

// File: tb/tb_gps_spi_bridge.sv
// Scoreboard bench for gps_spi_bridge: packer model pushes expected words, an SPI monitor
// collects frames, and each scenario task compares received frames and status outputs.
module tb_gps_spi_bridge;

   logic        MCU_CLK    = 1'b0;
   logic        RESET_N    = 1'b0;
   logic [3:0]  GPS_DATA   = 4'h0;
   logic        GPS_STROBE = 1'b0;
   logic        SELF_TEST  = 1'b0;
   logic        DATAREADY  = 1'b0;
   logic        MCU_SCK;
   logic        MCU_SS;
   logic        MCU_MOSI;
   logic        OVERFLOW;
   logic [2:0]  FIFO_LEVEL;

   gps_spi_bridge dut (
      .MCU_CLK    (MCU_CLK),
      .RESET_N    (RESET_N),
      .GPS_DATA   (GPS_DATA),
      .GPS_STROBE (GPS_STROBE),
      .SELF_TEST  (SELF_TEST),
      .DATAREADY  (DATAREADY),
      .MCU_SCK    (MCU_SCK),
      .MCU_SS     (MCU_SS),
      .MCU_MOSI   (MCU_MOSI),
      .OVERFLOW   (OVERFLOW),
      .FIFO_LEVEL (FIFO_LEVEL)
   );

   always #5 MCU_CLK = ~MCU_CLK;

   int n_tests = 0;
   int n_fail  = 0;

   logic [15:0] exp_q   [$];
   logic [15:0] rx_data [$];
   int          rx_bits [$];
   int          starts  [$];
   int          gaps    [$];

   int          cyc       = 0;
   logic        prev_ss   = 1'b1;
   int          ss_run    = 0;
   bit          have_prev = 1'b0;
   bit          mon_on    = 1'b0;
   logic [15:0] rx_sh     = 16'h0;
   int          rx_n      = 0;
   int          sck_total = 0;
   int          sck_bad   = 0;

   logic [3:0]  m_st   = 4'h0;
   logic [15:0] m_word = 16'h0;
   int          m_cnt  = 0;
   bit          m_done = 1'b0;

   // SPI bit capture on the rising SCK edge
   always @(posedge MCU_SCK) begin
      if (mon_on) begin
         sck_total++;
         if (MCU_SS) sck_bad++;
         else begin
            rx_sh = {rx_sh[14:0], MCU_MOSI};
            rx_n++;
         end
      end
   end

   // frame boundaries, start cycles and SS-high gap lengths
   always @(posedge MCU_CLK) begin
      #1;
      cyc++;
      if (mon_on) begin
         if (prev_ss && !MCU_SS) begin
            starts.push_back(cyc);
            if (have_prev) gaps.push_back(ss_run);
            rx_n  = 0;
            rx_sh = 16'h0;
         end
         if (!prev_ss && MCU_SS) begin
            rx_data.push_back(rx_sh);
            rx_bits.push_back(rx_n);
            have_prev = 1'b1;
            ss_run    = 0;
         end
         if (MCU_SS) ss_run++;
         prev_ss = MCU_SS;
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
      $fatal(1, "watchdog");
   end

   task automatic idle(input int n);
      repeat (n) @(posedge MCU_CLK);
      #1;
   endtask

   task automatic do_strobe(input logic [3:0] d);
      logic [3:0] src;
      if (!SELF_TEST) m_st = 4'h0;
      src = SELF_TEST ? m_st : d;
      GPS_DATA   = d;
      GPS_STROBE = 1'b1;
      @(posedge MCU_CLK);
      #1;
      GPS_STROBE = 1'b0;
      if (SELF_TEST) m_st = m_st + 4'h1;
      m_word = {m_word[11:0], src};
      m_cnt++;
      m_done = (m_cnt == 4);
      if (m_done) m_cnt = 0;
   endtask

   task automatic apply_reset();
      RESET_N = 1'b0;
      idle(3);
      RESET_N = 1'b1;
      m_st = 4'h0; m_word = 16'h0; m_cnt = 0; m_done = 1'b0;
      exp_q.delete(); rx_data.delete(); rx_bits.delete();
      starts.delete(); gaps.delete();
      have_prev = 1'b0;
      sck_bad   = 0;
   endtask

   task automatic test_reset();
      RESET_N = 1'b0;
      idle(3);
      mon_on = 1'b1;
      n_tests++; if (MCU_SS !== 1'b1) begin n_fail++; $display("FAIL reset_ss: got %b want 1", MCU_SS); end
      n_tests++; if (MCU_MOSI !== 1'b0) begin n_fail++; $display("FAIL reset_mosi: got %b want 0", MCU_MOSI); end
      n_tests++; if (OVERFLOW !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b want 0", OVERFLOW); end
      n_tests++; if (FIFO_LEVEL !== 3'd0) begin n_fail++; $display("FAIL reset_level: got %0d want 0", FIFO_LEVEL); end
      @(negedge MCU_CLK); #1;
      n_tests++; if (MCU_SCK !== 1'b0) begin n_fail++; $display("FAIL reset_sck: got %b want 0", MCU_SCK); end
      RESET_N = 1'b1;
      idle(1);
   endtask

   task automatic test_self_test();
      logic [15:0] got, e;
      int nb;
      SELF_TEST = 1'b1;
      DATAREADY = 1'b1;
      for (int i = 0; i < 4; i++) begin
         do_strobe(4'h0);
         if (m_done) exp_q.push_back(m_word);
      end
      n_tests++; if (FIFO_LEVEL !== 3'd1) begin n_fail++; $display("FAIL st_level: got %0d want 1", FIFO_LEVEL); end
      for (int i = 0; i < 60 && rx_data.size() < 1; i++) idle(1);
      n_tests++;
      if (rx_data.size() < 1 || exp_q.size() < 1) begin
         n_fail++; $display("FAIL st_frame_timeout: got %0d frames want 1", rx_data.size());
      end else begin
         got = rx_data.pop_front(); nb = rx_bits.pop_front(); e = exp_q.pop_front();
         n_tests++; if (got !== e) begin n_fail++; $display("FAIL st_data_sb: got %h want %h", got, e); end
         n_tests++; if (got !== 16'h0123) begin n_fail++; $display("FAIL st_data: got %h want 0123", got); end
         n_tests++; if (nb !== 16) begin n_fail++; $display("FAIL st_bits: got %0d want 16", nb); end
      end
      idle(3);
      n_tests++; if (MCU_SS !== 1'b1) begin n_fail++; $display("FAIL st_ss_hold: got %b want 1", MCU_SS); end
      n_tests++; if (FIFO_LEVEL !== 3'd0) begin n_fail++; $display("FAIL st_level_end: got %0d want 0", FIFO_LEVEL); end
      n_tests++; if (sck_bad !== 0) begin n_fail++; $display("FAIL st_sck_ss_high: got %0d want 0", sck_bad); end
      SELF_TEST = 1'b0;
      DATAREADY = 1'b0;
   endtask

   task automatic test_live();
      logic [3:0] pat [4] = '{4'hA, 4'h5, 4'hF, 4'h0};
      logic [15:0] got, e;
      int nb;
      DATAREADY = 1'b1;
      for (int i = 0; i < 4; i++) begin
         do_strobe(pat[i]);
         if (m_done) exp_q.push_back(m_word);
         idle(1);
      end
      for (int i = 0; i < 60 && rx_data.size() < 1; i++) idle(1);
      n_tests++;
      if (rx_data.size() < 1 || exp_q.size() < 1) begin
         n_fail++; $display("FAIL live_timeout: got %0d frames want 1", rx_data.size());
      end else begin
         got = rx_data.pop_front(); nb = rx_bits.pop_front(); e = exp_q.pop_front();
         n_tests++; if (got !== e) begin n_fail++; $display("FAIL live_data_sb: got %h want %h", got, e); end
         n_tests++; if (got !== 16'hA5F0) begin n_fail++; $display("FAIL live_data: got %h want a5f0", got); end
         n_tests++; if (nb !== 16) begin n_fail++; $display("FAIL live_bits: got %0d want 16", nb); end
      end
      DATAREADY = 1'b0;
      idle(4);
   endtask

   task automatic test_overflow();
      logic [15:0] tab [4] = '{16'h0123, 16'h4567, 16'h89AB, 16'hCDEF};
      logic [15:0] got, e;
      int nb;
      int lvl = 0;
      bit ovf = 1'b0;
      DATAREADY = 1'b0;
      SELF_TEST = 1'b1;
      for (int i = 0; i < 20; i++) begin
         do_strobe(4'h0);
         if (m_done) begin
            if (lvl < 4) begin exp_q.push_back(m_word); lvl++; end
            else ovf = 1'b1;
         end
         n_tests++; if (FIFO_LEVEL !== 3'(lvl)) begin n_fail++; $display("FAIL ovf_level[%0d]: got %0d want %0d", i, FIFO_LEVEL, lvl); end
         n_tests++; if (OVERFLOW !== ovf) begin n_fail++; $display("FAIL ovf_flag[%0d]: got %b want %b", i, OVERFLOW, ovf); end
      end
      SELF_TEST = 1'b0;
      DATAREADY = 1'b1;
      for (int i = 0; i < 200 && rx_data.size() < 4; i++) idle(1);
      n_tests++;
      if (rx_data.size() < 4 || exp_q.size() < 4) begin
         n_fail++; $display("FAIL ovf_timeout: got %0d frames want 4", rx_data.size());
      end else begin
         for (int k = 0; k < 4; k++) begin
            got = rx_data.pop_front(); nb = rx_bits.pop_front(); e = exp_q.pop_front();
            n_tests++; if (got !== e) begin n_fail++; $display("FAIL ovf_data_sb[%0d]: got %h want %h", k, got, e); end
            n_tests++; if (got !== tab[k]) begin n_fail++; $display("FAIL ovf_data[%0d]: got %h want %h", k, got, tab[k]); end
            n_tests++; if (nb !== 16) begin n_fail++; $display("FAIL ovf_bits[%0d]: got %0d want 16", k, nb); end
         end
      end
      idle(40);
      n_tests++; if (rx_data.size() !== 0) begin n_fail++; $display("FAIL ovf_extra_frames: got %0d want 0", rx_data.size()); end
      n_tests++; if (FIFO_LEVEL !== 3'd0) begin n_fail++; $display("FAIL ovf_level_end: got %0d want 0", FIFO_LEVEL); end
      n_tests++; if (OVERFLOW !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b want 1", OVERFLOW); end
      DATAREADY = 1'b0;
   endtask

   task automatic test_back_to_back();
      logic [15:0] got, e;
      int nb;
      apply_reset();
      n_tests++; if (OVERFLOW !== 1'b0) begin n_fail++; $display("FAIL b2b_ovf_cleared: got %b want 0", OVERFLOW); end
      DATAREADY = 1'b1;
      SELF_TEST = 1'b0;
      for (int i = 0; i < 32; i++) begin
         do_strobe(4'($urandom_range(0, 15)));
         if (m_done) exp_q.push_back(m_word);
         idle(3);
      end
      for (int i = 0; i < 300 && rx_data.size() < 8; i++) idle(1);
      n_tests++;
      if (rx_data.size() < 8 || exp_q.size() < 8 || starts.size() < 8) begin
         n_fail++; $display("FAIL b2b_timeout: got %0d frames want 8", rx_data.size());
      end else begin
         for (int k = 0; k < 8; k++) begin
            got = rx_data.pop_front(); nb = rx_bits.pop_front(); e = exp_q.pop_front();
            n_tests++; if (got !== e) begin n_fail++; $display("FAIL b2b_data[%0d]: got %h want %h", k, got, e); end
            n_tests++; if (nb !== 16) begin n_fail++; $display("FAIL b2b_bits[%0d]: got %0d want 16", k, nb); end
         end
         for (int k = 1; k < 8; k++) begin
            n_tests++;
            if (starts[k] - starts[k-1] !== 19) begin
               n_fail++; $display("FAIL b2b_period[%0d]: got %0d want 19", k, starts[k] - starts[k-1]);
            end
         end
         n_tests++; if (gaps.size() !== 7) begin n_fail++; $display("FAIL b2b_gap_count: got %0d want 7", gaps.size()); end
         foreach (gaps[k]) begin
            n_tests++; if (gaps[k] !== 3) begin n_fail++; $display("FAIL b2b_gap[%0d]: got %0d want 3", k, gaps[k]); end
         end
      end
      n_tests++; if (OVERFLOW !== 1'b0) begin n_fail++; $display("FAIL b2b_ovf: got %b want 0", OVERFLOW); end
      n_tests++; if (sck_bad !== 0) begin n_fail++; $display("FAIL b2b_sck_ss_high: got %0d want 0", sck_bad); end
      DATAREADY = 1'b0;
      idle(4);
   endtask

   task automatic test_reset_mid_frame();
      logic [3:0] pat [4] = '{4'hC, 4'h3, 4'h9, 4'h6};
      logic [15:0] got, e;
      int nb, t0;
      bit hit = 1'b0;
      apply_reset();
      DATAREADY = 1'b0;
      for (int i = 0; i < 8; i++) do_strobe(4'(i + 1));
      n_tests++; if (FIFO_LEVEL !== 3'd2) begin n_fail++; $display("FAIL rm_level_pre: got %0d want 2", FIFO_LEVEL); end
      DATAREADY = 1'b1;
      for (int i = 0; i < 60 && !hit; i++) begin
         @(negedge MCU_CLK); #1;
         if (!MCU_SS && rx_n >= 5) hit = 1'b1;
      end
      n_tests++; if (!hit) begin n_fail++; $display("FAIL rm_no_pulses: got %0d pulses want 5", rx_n); end
      RESET_N = 1'b0;
      t0 = sck_total;
      @(posedge MCU_CLK); #2;
      n_tests++; if (MCU_SS !== 1'b1) begin n_fail++; $display("FAIL rm_ss: got %b want 1", MCU_SS); end
      n_tests++; if (FIFO_LEVEL !== 3'd0) begin n_fail++; $display("FAIL rm_level: got %0d want 0", FIFO_LEVEL); end
      n_tests++; if (MCU_MOSI !== 1'b0) begin n_fail++; $display("FAIL rm_mosi: got %b want 0", MCU_MOSI); end
      idle(2);
      RESET_N = 1'b1;
      idle(6);
      n_tests++; if (sck_total !== t0) begin n_fail++; $display("FAIL rm_sck_after: got %0d pulses want 0", sck_total - t0); end
      n_tests++;
      if (rx_data.size() !== 1) begin
         n_fail++; $display("FAIL rm_partial_count: got %0d want 1", rx_data.size());
      end else begin
         got = rx_data.pop_front(); nb = rx_bits.pop_front();
         n_tests++; if (nb !== 5) begin n_fail++; $display("FAIL rm_partial_bits: got %0d want 5", nb); end
         n_tests++; if (got !== 16'h0002) begin n_fail++; $display("FAIL rm_partial_data: got %h want 0002", got); end
      end
      m_st = 4'h0; m_word = 16'h0; m_cnt = 0;
      exp_q.delete(); rx_data.delete(); rx_bits.delete();
      for (int i = 0; i < 4; i++) begin
         do_strobe(pat[i]);
         if (m_done) exp_q.push_back(m_word);
      end
      for (int i = 0; i < 60 && rx_data.size() < 1; i++) idle(1);
      n_tests++;
      if (rx_data.size() < 1 || exp_q.size() < 1) begin
         n_fail++; $display("FAIL rm_fresh_timeout: got %0d frames want 1", rx_data.size());
      end else begin
         got = rx_data.pop_front(); nb = rx_bits.pop_front(); e = exp_q.pop_front();
         n_tests++; if (got !== e) begin n_fail++; $display("FAIL rm_fresh_sb: got %h want %h", got, e); end
         n_tests++; if (got !== 16'hC396) begin n_fail++; $display("FAIL rm_fresh_data: got %h want c396", got); end
         n_tests++; if (nb !== 16) begin n_fail++; $display("FAIL rm_fresh_bits: got %0d want 16", nb); end
      end
      idle(30);
      n_tests++; if (rx_data.size() !== 0) begin n_fail++; $display("FAIL rm_stale_frames: got %0d want 0", rx_data.size()); end
      DATAREADY = 1'b0;
   endtask

   initial begin
      test_reset();
      test_self_test();
      test_live();
      test_overflow();
      test_back_to_back();
      test_reset_mid_frame();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
